// File: rtl/ofdm_bit_packer.sv
// Packs Gray-coded OFDM symbol bits MSB-first into OUT_WIDTH-bit words, with a passthrough mode.
// Define OFDM_BIT_PACKER_CNT_EN to add the o_word_cnt accepted-word counter output.
module ofdm_bit_packer #(
  parameter int MAX_BITS_PER_SYM    = 6,
  parameter int OUT_WIDTH           = 32,
  parameter int SR_MODULATION_ORDER = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        set_stb,
  input  logic [7:0]                  set_addr,
  input  logic [31:0]                 set_data,
  input  logic [MAX_BITS_PER_SYM-1:0] i_tdata,
  input  logic                        i_tlast,
  input  logic                        i_tvalid,
  output logic                        i_tready,
  output logic [OUT_WIDTH-1:0]        o_tdata,
  output logic                        o_tlast,
  output logic                        o_tvalid,
  input  logic                        o_tready
`ifdef OFDM_BIT_PACKER_CNT_EN
  ,
  output logic [31:0]                 o_word_cnt
`endif
);

  localparam int OW    = $clog2(MAX_BITS_PER_SYM) + 1;
  localparam int ACC_W = OUT_WIDTH + MAX_BITS_PER_SYM;
  localparam int CW    = $clog2(ACC_W + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_t;

  state_t               state, state_n;
  logic [OW-1:0]        order_reg, active_order, act_n, ord;
  logic [ACC_W-1:0]     acc, acc_n, cat, res, ord_mask;
  logic [CW-1:0]        cnt, cnt_n, sum, rcnt;
  logic [OUT_WIDTH-1:0] data_n;
  logic                 vld_n, last_n, rdy_en, pack, full, in_hs, out_hs;

  // Out-of-range writes saturate, which lands in passthrough like any order above the max.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      order_reg <= '0;
    else if (set_stb && set_addr == 8'(SR_MODULATION_ORDER))
      order_reg <= (|set_data[31:OW]) ? '1 : set_data[OW-1:0];
  end

  assign i_tready = rdy_en & (!o_tvalid | o_tready) & (state != FLUSH);
  assign in_hs    = i_tvalid & i_tready;
  assign out_hs   = o_tvalid & o_tready;

  // Accumulator holds cnt valid bits right-justified; the oldest bit sits highest.
  always_comb begin
    ord      = (state == IDLE) ? order_reg : active_order;
    pack     = (ord != '0) && (ord <= OW'(MAX_BITS_PER_SYM));
    ord_mask = (ACC_W'(1) << ord) - ACC_W'(1);
    cat      = (acc << ord) | (ACC_W'(i_tdata) & ord_mask);
    sum      = cnt + CW'(ord);
    full     = (sum >= CW'(OUT_WIDTH));
    rcnt     = sum - CW'(OUT_WIDTH);
    res      = cat & ((ACC_W'(1) << rcnt) - ACC_W'(1));
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    act_n   = active_order;
    vld_n   = o_tvalid;
    data_n  = o_tdata;
    last_n  = o_tlast;
    if (clear) begin
      state_n = IDLE;
      acc_n   = '0;
      cnt_n   = '0;
      vld_n   = 1'b0;
    end else if (state == FLUSH) begin
      // cnt != 0: full word still pending; cnt == 0: padded word is in the output register
      if (out_hs) begin
        if (cnt != '0) begin
          data_n = OUT_WIDTH'(acc << (CW'(OUT_WIDTH) - cnt));
          last_n = 1'b1;
          vld_n  = 1'b1;
          acc_n  = '0;
          cnt_n  = '0;
        end else begin
          vld_n   = 1'b0;
          state_n = IDLE;
        end
      end
    end else begin
      if (out_hs) vld_n = 1'b0;
      if (in_hs) begin
        if (state == IDLE) act_n = order_reg;
        if (!pack) begin
          vld_n   = 1'b1;
          data_n  = OUT_WIDTH'(i_tdata);
          last_n  = i_tlast;
          state_n = i_tlast ? IDLE : ACCUM;
        end else if (full) begin
          vld_n  = 1'b1;
          data_n = OUT_WIDTH'(cat >> rcnt);
          acc_n  = res;
          cnt_n  = rcnt;
          if (i_tlast && rcnt != '0) begin
            last_n  = 1'b0;
            state_n = FLUSH;
          end else begin
            last_n  = i_tlast;
            state_n = i_tlast ? IDLE : ACCUM;
          end
        end else if (i_tlast) begin
          vld_n   = 1'b1;
          data_n  = OUT_WIDTH'(cat << (CW'(OUT_WIDTH) - sum));
          last_n  = 1'b1;
          acc_n   = '0;
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          acc_n   = cat;
          cnt_n   = sum;
          state_n = ACCUM;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      acc          <= '0;
      cnt          <= '0;
      active_order <= '0;
      o_tvalid     <= 1'b0;
      o_tdata      <= '0;
      o_tlast      <= 1'b0;
      rdy_en       <= 1'b0;
    end else begin
      state        <= state_n;
      acc          <= acc_n;
      cnt          <= cnt_n;
      active_order <= act_n;
      o_tvalid     <= vld_n;
      o_tdata      <= data_n;
      o_tlast      <= last_n;
      rdy_en       <= 1'b1;
    end
  end

`ifdef OFDM_BIT_PACKER_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       o_word_cnt <= '0;
    else if (clear)  o_word_cnt <= '0;
    else if (out_hs) o_word_cnt <= o_word_cnt + 32'd1;
  end
`endif

endmodule

// File: doc/ofdm_bit_packer.md
OFDM_BIT_PACKER -- requirements
Module: ofdm_bit_packer

Interface
REQ-001 The block SHALL have parameter MAX_BITS_PER_SYM, default 6, meaning the largest bits-per-symbol supported, in the range 1..OUT_WIDTH/2.
REQ-002 The block SHALL have parameter OUT_WIDTH, default 32, meaning the packed output word width, a multiple of 8.
REQ-003 The block SHALL have parameter SR_MODULATION_ORDER, default 0, meaning the settings-register address of the bits-per-symbol register.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port clear, input, 1 bit: synchronous flush.
REQ-007 The block SHALL have ports set_stb (input, 1), set_addr (input, 8) and set_data (input, 32): the settings bus.
REQ-008 The block SHALL have ports i_tdata (input, MAX_BITS_PER_SYM), i_tlast (input, 1), i_tvalid (input, 1) and i_tready (output, 1): Gray-coded symbol bits, right-justified in i_tdata, with i_tlast marking the OFDM symbol end.
REQ-009 The block SHALL have ports o_tdata (output, OUT_WIDTH), o_tlast (output, 1), o_tvalid (output, 1) and o_tready (input, 1): packed words.

Function
REQ-010 The block SHALL hold a bits-per-symbol register, width $clog2(MAX_BITS_PER_SYM)+1, written when set_stb is high and set_addr equals SR_MODULATION_ORDER; its reset value SHALL be 0.
REQ-011 The block SHALL latch the register into active_order on the first input handshake of each packet (accumulator empty, state IDLE); writes made mid-packet SHALL take effect only from the next packet.
REQ-012 Pack mode SHALL apply when active_order is in 1..MAX_BITS_PER_SYM: each handshake appends i_tdata[active_order-1:0], MSB-first, to an accumulator of OUT_WIDTH+MAX_BITS_PER_SYM bits; the first symbol SHALL land in the MSBs of the word.
REQ-013 When the accumulated bit count reaches or exceeds OUT_WIDTH, the block SHALL emit the top OUT_WIDTH bits as one word, and the residue SHALL carry into the next word with no bits lost; this covers non-divisible orders such as 3, 5 and 6.
REQ-014 On a handshake with i_tlast=1, any partial word SHALL be emitted left-justified and zero-padded in the LSBs, with o_tlast=1, and the accumulator SHALL return to empty.
REQ-015 If a tlast handshake produces both a full word and a non-empty residue, the block SHALL emit the full word with o_tlast=0 and then the padded word with o_tlast=1, in state FLUSH.
REQ-016 If a tlast handshake lands exactly on a word boundary, the block SHALL emit a single word with o_tlast=1 and no padded word.
REQ-017 Passthrough mode SHALL apply when active_order is 0 or greater than MAX_BITS_PER_SYM: every input beat SHALL produce one word equal to i_tdata zero-extended, with o_tlast=i_tlast.
REQ-018 The block SHALL use the states IDLE (empty, awaiting a packet), ACCUM (packet in progress) and FLUSH (second word pending); transitions SHALL be IDLE->ACCUM on a non-tlast handshake, ACCUM->IDLE on a tlast without a second word, and ACCUM/IDLE->FLUSH->IDLE per REQ-015.
REQ-019 The output SHALL be a single register stage; o_tvalid SHALL rise the cycle after the input handshake that completes a word.
REQ-020 i_tready SHALL equal (!o_tvalid | o_tready) & (state != FLUSH).
REQ-021 In FLUSH, i_tready SHALL be 0 until the padded word is accepted.
REQ-022 o_tdata and o_tlast SHALL hold stable while o_tvalid=1 and o_tready=0.
REQ-023 When both an output handshake and an input handshake occur in the same cycle, the block SHALL honour both with no bubble and no lost word.
REQ-024 clear SHALL empty the accumulator, deassert o_tvalid, go to IDLE and discard any partial word; it SHALL NOT alter the settings register.

Reset
REQ-025 Asserting reset SHALL immediately force o_tvalid=0, o_tdata=0, o_tlast=0, i_tready=0, bit count 0, active_order 0, the register to 0 and state IDLE, independent of clk.
REQ-026 After reset deasserts, i_tready SHALL be 1 from the next clk edge, and any packet interrupted by reset SHALL be lost without any output.

Configuration
REQ-027 With OFDM_BIT_PACKER_CNT_EN defined, the block SHALL add output o_word_cnt [31:0], counting accepted output words, reset and cleared to 0, and wrapping from 0xFFFFFFFF to 0.
REQ-028 Without OFDM_BIT_PACKER_CNT_EN, the port and counter SHALL be absent, with no other behavioural change.

Verification
REQ-029 Order 2, sixteen symbols 2'b11 with i_tlast on the 16th -> the bench SHALL see one word 0xFFFFFFFF with o_tlast=1.
REQ-030 Order 6, five symbols 6'h3F with tlast on the 5th -> the bench SHALL see one word 0xFFFFFFFC with o_tlast=1.
REQ-031 Order 6, six symbols 6'h3F with tlast on the 6th -> the bench SHALL see 0xFFFFFFFF (o_tlast=0), then 0xF0000000 (o_tlast=1), with i_tready low during FLUSH.
REQ-032 Order 1, 32 alternating bits starting with 1, with o_tready toggling every cycle -> the bench SHALL see 0xAAAAAAAA, held stable while stalled.
REQ-033 Order 0, beat 0x25 with tlast -> the bench SHALL see 0x00000025 with o_tlast=1; the same input with order 7 written mid-packet under order 0 -> the bench SHALL see passthrough kept until the next packet.
REQ-034 Reset asserted between clk edges mid-packet -> the bench SHALL see o_tvalid drop at once and no residual word after release.
